// File: rtl/alu_arb.sv
// Two-requester front end for a shared combinational ALU: arbitrate, issue one op, hold the response.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arb #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid_0,
  output logic             o_req_ready_0,
  input  logic [WIDTH-1:0] i_req_a_0,
  input  logic [WIDTH-1:0] i_req_b_0,
  input  logic [3:0]       i_req_sel_0,
  input  logic             i_req_sign_0,
  input  logic             i_req_valid_1,
  output logic             o_req_ready_1,
  input  logic [WIDTH-1:0] i_req_a_1,
  input  logic [WIDTH-1:0] i_req_b_1,
  input  logic [3:0]       i_req_sel_1,
  input  logic             i_req_sign_1,
  output logic             o_rsp_valid_0,
  input  logic             i_rsp_ready_0,
  output logic             o_rsp_valid_1,
  input  logic             i_rsp_ready_1,
  output logic [WIDTH-1:0] o_rsp_result,
  output logic             o_rsp_zero,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [3:0]       o_alu_sel,
  output logic             o_alu_sign,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_zero,
  output logic             o_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       sel;
    logic             sign;
  } req_t;

  state_t           state, state_n;
  req_t [1:0]       req;
  req_t             op_q;
  logic [1:0]       vld, rsp_rdy;
  logic             gnt, win, accept;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;

  assign req[0]  = {i_req_a_0, i_req_b_0, i_req_sel_0, i_req_sign_0};
  assign req[1]  = {i_req_a_1, i_req_b_1, i_req_sel_1, i_req_sign_1};
  assign vld     = {i_req_valid_1, i_req_valid_0};
  assign rsp_rdy = {i_rsp_ready_1, i_rsp_ready_0};

`ifdef ALU_ARB_RR_EN
  logic last_gnt;
  // On conflict the requester not served last wins.
  always_comb win = (&vld) ? ~last_gnt : ~vld[0];
`else
  always_comb win = ~vld[0];
`endif

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if ((|vld) && !i_rst) begin
          accept  = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: state_n = RESP;
      // Only the granted requester's ready can retire the response.
      RESP: if (rsp_rdy[gnt]) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_q     <= '0;
      gnt      <= 1'b0;
      res_q    <= '0;
      zero_q   <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_gnt <= 1'b1;
`endif
    end else begin
      if (accept) begin
        op_q     <= req[win];
        gnt      <= win;
`ifdef ALU_ARB_RR_EN
        last_gnt <= win;
`endif
      end
      if (state == ISSUE) begin
        res_q  <= i_alu_result;
        zero_q <= i_alu_zero;
      end
    end
  end

  assign o_req_ready_0 = accept & ~win;
  assign o_req_ready_1 = accept &  win;
  assign o_rsp_valid_0 = (state == RESP) & ~gnt;
  assign o_rsp_valid_1 = (state == RESP) &  gnt;
  assign o_rsp_result  = res_q;
  assign o_rsp_zero    = zero_q;
  assign o_alu_a       = op_q.a;
  assign o_alu_b       = op_q.b;
  assign o_alu_sel     = op_q.sel;
  assign o_alu_sign    = op_q.sign;
  assign o_busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_arb.sv
// Bench for alu_arb: transaction-stage model checked every cycle, plus directed literal scenarios.
module tb_alu_arb;
  localparam int W = 32;

  logic         clk = 1'b0, rst = 1'b1;
  logic         v0 = 0, v1 = 0, rr0 = 1, rr1 = 1;
  logic [W-1:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [3:0]   s0 = 0, s1 = 0;
  logic         g0 = 0, g1 = 0;
  logic         rdy0, rdy1, rv0, rv1, rzero, asign, alu_zero, busy;
  logic [W-1:0] rres, aa, ab, alu_res;
  logic [3:0]   asel;

  always #5 clk = ~clk;

  alu_arb #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid_0(v0), .o_req_ready_0(rdy0), .i_req_a_0(a0), .i_req_b_0(b0), .i_req_sel_0(s0), .i_req_sign_0(g0),
    .i_req_valid_1(v1), .o_req_ready_1(rdy1), .i_req_a_1(a1), .i_req_b_1(b1), .i_req_sel_1(s1), .i_req_sign_1(g1),
    .o_rsp_valid_0(rv0), .i_rsp_ready_0(rr0), .o_rsp_valid_1(rv1), .i_rsp_ready_1(rr1),
    .o_rsp_result(rres), .o_rsp_zero(rzero),
    .o_alu_a(aa), .o_alu_b(ab), .o_alu_sel(asel), .o_alu_sign(asign),
    .i_alu_result(alu_res), .i_alu_zero(alu_zero), .o_busy(busy));

  // Reference ALU standing in for the external combinational unit.
  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] sel, input logic sign);
    case (sel)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a ^ b;
      4'b0011: return a + b;
      4'b0100: return a - b;
      4'b0101: return sign ? W'($signed(a) < $signed(b)) : W'(a < b);
      default: return '0;
    endcase
  endfunction

  assign alu_res  = alu_f(aa, ab, asel, asign);
  assign alu_zero = (alu_res == '0);

  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a transaction is idle (0), in flight to the ALU (1) or waiting on the consumer (2).
  int           m_stage = 0, m_gnt = 0, m_last = 1;
  logic [W-1:0] m_a = 0, m_b = 0, m_res = 0;
  logic [3:0]   m_sel = 0;
  logic         m_sign = 0, m_zero = 0;

  function automatic int m_win();
    if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
      return (m_last == 1) ? 0 : 1;
`else
      return 0;
`endif
    end
    return v0 ? 0 : 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_stage <= 0; m_gnt <= 0; m_last <= 1;
      m_a <= 0; m_b <= 0; m_sel <= 0; m_sign <= 0; m_res <= 0; m_zero <= 0;
    end else if (m_stage == 0) begin
      if (v0 || v1) begin
        m_gnt  <= m_win();
        m_last <= m_win();
        m_a    <= (m_win() == 0) ? a0 : a1;
        m_b    <= (m_win() == 0) ? b0 : b1;
        m_sel  <= (m_win() == 0) ? s0 : s1;
        m_sign <= (m_win() == 0) ? g0 : g1;
        m_stage <= 1;
      end
    end else if (m_stage == 1) begin
      m_res   <= alu_f(m_a, m_b, m_sel, m_sign);
      m_zero  <= (alu_f(m_a, m_b, m_sel, m_sign) == '0);
      m_stage <= 2;
    end else if ((m_gnt == 0) ? rr0 : rr1) begin
      m_stage <= 0;
    end
  end

  always @(negedge clk) begin
    logic e_acc;
    e_acc = !rst && (m_stage == 0) && (v0 || v1);
    chk("ready_0",  W'(rdy0),  W'(e_acc && m_win() == 0));
    chk("ready_1",  W'(rdy1),  W'(e_acc && m_win() == 1));
    chk("rsp_valid_0", W'(rv0), W'(m_stage == 2 && m_gnt == 0));
    chk("rsp_valid_1", W'(rv1), W'(m_stage == 2 && m_gnt == 1));
    chk("busy",     W'(busy),  W'(m_stage != 0));
    chk("result",   rres,      m_res);
    chk("zero",     W'(rzero), W'(m_zero));
    chk("alu_a",    aa,        m_a);
    chk("alu_b",    ab,        m_b);
    chk("alu_sel",  W'(asel),  W'(m_sel));
    chk("alu_sign", W'(asign), W'(m_sign));
  end

  function automatic logic rdy_of(input int n);  return n ? rdy1 : rdy0; endfunction
  function automatic logic rsp_of(input int n);  return n ? rv1 : rv0;   endfunction

  task automatic drive(input int n, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] sel, input logic sign);
    if (n == 0) begin v0 = v; a0 = a; b0 = b; s0 = sel; g0 = sign; end
    else        begin v1 = v; a1 = a; b1 = b; s1 = sel; g1 = sign; end
  endtask

  // Raise a request, wait for its accept and response; returns at the negedge where the response shows.
  task automatic issue(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] sel,
                       input logic sign, output logic [W-1:0] res, output logic z, output int lat,
                       output int waits, output bit other);
    bit ok;
    int acc;
    drive(n, 1'b1, a, b, sel, sign);
    ok = 0; waits = 0; other = 0; res = '0; z = 0; lat = -1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rdy_of(n)) ok = 1; else waits++;
    end
    if (!ok) begin chk("accept_timeout", 0, 1); drive(n, 1'b0, a, b, sel, sign); return; end
    acc = cyc;
    @(posedge clk); #2;
    drive(n, 1'b0, a, b, sel, sign);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rsp_of(1 - n)) other = 1;
      if (rsp_of(n)) ok = 1;
    end
    if (!ok) begin chk("response_timeout", 0, 1); return; end
    lat = cyc - acc; res = rres; z = rzero;
  endtask

  task automatic settle();
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk); #2;
  endtask

  logic [W-1:0] res;
  logic         z;
  int           lat, waits, k;
  bit           other, seen;
  int           order[4];
  int           exp_order[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
`ifdef ALU_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    // Reset with a request already pending; it must not see ready until release.
    drive(0, 1'b1, 5, 3, 4'b0011, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready_0", W'(rdy0), 0);
    chk("reset_busy",    W'(busy), 0);
    chk("reset_alu_a",   aa,       0);
    @(posedge clk); #2;
    rst = 0;

    // Req0 add, accepted in the first cycle after reset.
    issue(0, 5, 3, 4'b0011, 0, res, z, lat, waits, other);
    chk("t1_first_cycle_accept", W'(waits), 0);
    chk("t1_result", res, 8);
    chk("t1_zero",   W'(z), 0);
    chk("t1_latency", W'(lat), 2);
    chk("t1_no_rsp1", W'(other), 0);
    settle();

    // Req1 sub to zero.
    issue(1, 7, 7, 4'b0100, 0, res, z, lat, waits, other);
    chk("t2_result", res, 0);
    chk("t2_zero",   W'(z), 1);
    chk("t2_latency", W'(lat), 2);
    chk("t2_no_rsp0", W'(other), 0);
    settle();

    // Signed vs unsigned set-less-than of -1 against 1.
    issue(0, '1, 1, 4'b0101, 1, res, z, lat, waits, other);
    chk("t3_slt_signed", res, 1);
    settle();
    issue(1, '1, 1, 4'b0101, 0, res, z, lat, waits, other);
    chk("t3_slt_unsigned", res, 0);
    chk("t3_zero", W'(z), 1);
    settle();

    // Both requesters valid continuously for four accepts.
    drive(0, 1'b1, 11, 1, 4'b0011, 0);
    drive(1, 1'b1, 22, 2, 4'b0011, 0);
    k = 0;
    for (int i = 0; i < 60 && k < 4; i++) begin
      @(negedge clk);
      if (rdy0) begin order[k] = 0; k++; end
      else if (rdy1) begin order[k] = 1; k++; end
    end
    @(posedge clk); #2;
    v0 = 0; v1 = 0;
    chk("t4_accepts", W'(k), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t4_grant%0d", i), W'(order[i]), W'(exp_order[i]));
    settle();

    // Response stall: req0 held in RESP while req1 waits; req1's ready is ignored meanwhile.
    rr0 = 0; rr1 = 1;
    drive(1, 1'b1, 3, 9, 4'b0010, 0);
    issue(0, 10, 20, 4'b0011, 0, res, z, lat, waits, other);
    chk("t5_result", res, 30);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rv0 && !rv1 && rres == 30 && !rdy1 && busy) k++;
    end
    chk("t5_stable_cycles", W'(k), 10);
    @(posedge clk); #2;
    rr0 = 1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_req1_next_idle", W'(rdy1), 1);
    @(posedge clk); #2;
    v1 = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rv1) seen = 1;
    end
    chk("t5_req1_seen", W'(seen), 1);
    chk("t5_req1_result", rres, 10);
    settle();

    // Reset pulsed while a response is pending.
    rr0 = 0;
    issue(0, 6, 4, 4'b0100, 0, res, z, lat, waits, other);
    chk("t6_pre_result", res, 2);
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk("t6_rsp_drop",  W'(rv0),  0);
    chk("t6_result_0",  rres,     0);
    chk("t6_busy_0",    W'(busy), 0);
    chk("t6_alu_b_0",   ab,       0);
    @(posedge clk); #2;
    rst = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rv0 || rv1 || busy) seen = 1;
    end
    chk("t6_no_rsp_after", W'(seen), 0);
    rr0 = 1;
    issue(0, 1, 2, 4'b0001, 0, res, z, lat, waits, other);
    chk("t6_or_result", res, 3);
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
